// File: rtl/hamming16t11d_scrub_reg_if.sv
// Bus bundle for the scrubbed SEC-DED storage stage.
// The master drives load/inject/clear and receives the checked data and event status.
interface hamming16t11d_scrub_reg_if #(
    parameter int unsigned CNT_W = 8
);
    logic             load_i;
    logic [15:0]      hv_i;
    logic [15:0]      inj_mask_i;
    logic             clr_i;
    logic [10:0]      data_o;
    logic             valid_o;
    logic             sec_o;
    logic             ded_o;
    logic             ded_sticky_o;
    logic [CNT_W-1:0] cnt_sec_o;
    logic [CNT_W-1:0] cnt_ded_o;

    modport master (
        output load_i, hv_i, inj_mask_i, clr_i,
        input  data_o, valid_o, sec_o, ded_o, ded_sticky_o, cnt_sec_o, cnt_ded_o
    );

    modport slave (
        input  load_i, hv_i, inj_mask_i, clr_i,
        output data_o, valid_o, sec_o, ded_o, ded_sticky_o, cnt_sec_o, cnt_ded_o
    );
endinterface

// File: rtl/hamming16t11d_scrub_reg.sv
// Protected storage for one 16-bit SEC-DED Hamming word.
// The stored word is decoded every time it enters CHECK; single errors are written back
// corrected and re-verified, double errors park the stage in FAULT until the next load.
// While VALID, an optional timer forces a periodic re-check of the stored word.
module hamming16t11d_scrub_reg #(
    parameter int unsigned SCRUB_PERIOD = 64,
    parameter int unsigned CNT_W        = 8
) (
    input logic                       clk_i,
    input logic                       rstn_i,
    hamming16t11d_scrub_reg_if.slave  bus
);

    localparam logic [2:0] ST_EMPTY = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_SCRUB = 3'd2;
    localparam logic [2:0] ST_VALID = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam int unsigned        TIMER_W     = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(SCRUB_PERIOD - 1);
    localparam bit                 PERIODIC_EN = (SCRUB_PERIOD != 0);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    logic [2:0]         state_q, state_d;
    logic [15:0]        storage_q, storage_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_sec_q, cnt_sec_d;
    logic [CNT_W-1:0]   cnt_ded_q, cnt_ded_d;
    logic               sticky_q, sticky_d;

    logic [3:0]  syn;
    logic        par;
    logic        is_clean;
    logic        is_single;
    logic        is_double;
    logic [15:0] corrected;
    logic        sec_evt;
    logic        ded_evt;

    // Syndrome is the XOR of the positions of all set bits 1..15; parity covers all 16 bits.
    always_comb begin
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (storage_q[k]) begin
                syn = syn ^ 4'(k);
            end
        end
        par       = ^storage_q;
        is_clean  = (syn == 4'd0) && !par;
        is_single = par;
        is_double = (syn != 4'd0) && !par;
        // Syndrome 0 with odd parity points at the overall parity bit itself.
        corrected = storage_q ^ (16'd1 << syn);
    end

    assign sec_evt = (state_q == ST_CHECK) && is_single;
    assign ded_evt = (state_q == ST_CHECK) && is_double;

    // Next state, storage and re-check timer; a load overrides everything else.
    always_comb begin
        state_d   = state_q;
        storage_d = storage_q;
        timer_d   = timer_q;
        if (bus.load_i) begin
            storage_d = bus.hv_i ^ bus.inj_mask_i;
            state_d   = ST_CHECK;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    state_d = ST_EMPTY;
                end
                ST_CHECK: begin
                    if (is_clean) begin
                        state_d = ST_VALID;
                        timer_d = '0;
                    end else if (is_single) begin
                        state_d = ST_SCRUB;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
                ST_SCRUB: begin
                    storage_d = corrected;
                    state_d   = ST_CHECK;
                end
                ST_VALID: begin
                    if (PERIODIC_EN && (timer_q == TIMER_LAST)) begin
                        timer_d = '0;
                        state_d = ST_CHECK;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Saturating event counters and sticky DED flag; clear beats a same-cycle event.
    always_comb begin
        cnt_sec_d = cnt_sec_q;
        cnt_ded_d = cnt_ded_q;
        sticky_d  = sticky_q;
        if (bus.clr_i) begin
            cnt_sec_d = '0;
            cnt_ded_d = '0;
            sticky_d  = 1'b0;
        end else begin
            if (sec_evt && (cnt_sec_q != CNT_MAX)) begin
                cnt_sec_d = cnt_sec_q + 1'b1;
            end
            if (ded_evt) begin
                sticky_d = 1'b1;
                if (cnt_ded_q != CNT_MAX) begin
                    cnt_ded_d = cnt_ded_q + 1'b1;
                end
            end
        end
    end

    // State registers; reset drops everything at once, including a pending write-back.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_EMPTY;
            storage_q <= '0;
            timer_q   <= '0;
            cnt_sec_q <= '0;
            cnt_ded_q <= '0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            storage_q <= storage_d;
            timer_q   <= timer_d;
            cnt_sec_q <= cnt_sec_d;
            cnt_ded_q <= cnt_ded_d;
            sticky_q  <= sticky_d;
        end
    end

    // Data bits sit at positions 3,5,6,7,9..15 of the stored word.
    assign bus.data_o       = {storage_q[15:9], storage_q[7:5], storage_q[3]};
    assign bus.valid_o      = (state_q == ST_VALID);
    assign bus.sec_o        = sec_evt;
    assign bus.ded_o        = ded_evt;
    assign bus.ded_sticky_o = sticky_q;
    assign bus.cnt_sec_o    = cnt_sec_q;
    assign bus.cnt_ded_o    = cnt_ded_q;

endmodule

// File: tb/tb_hamming16t11d_scrub_reg.sv
// Directed bench for the scrubbed SEC-DED storage stage.
// encode(11'h5A5) = 16'hB44B, encode(11'h7FF) = 16'hFFFF, encode(11'h000) = 16'h0000.
module tb_hamming16t11d_scrub_reg;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    hamming16t11d_scrub_reg_if #(.CNT_W(8)) bm ();
    hamming16t11d_scrub_reg_if #(.CNT_W(8)) bp ();

    hamming16t11d_scrub_reg #(.SCRUB_PERIOD(64), .CNT_W(8)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bm)
    );

    hamming16t11d_scrub_reg #(.SCRUB_PERIOD(4), .CNT_W(8)) dut_p4 (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bp)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Load on the main DUT; returns at the negedge of cycle k+1 (FSM in CHECK).
    task automatic load_main(input logic [15:0] hv, input logic [15:0] mask);
        @(negedge clk);
        bm.load_i     = 1'b1;
        bm.hv_i       = hv;
        bm.inj_mask_i = mask;
        @(negedge clk);
        bm.load_i     = 1'b0;
        bm.inj_mask_i = 16'h0;
    endtask

    task automatic clr_main();
        @(negedge clk);
        bm.clr_i = 1'b1;
        @(negedge clk);
        bm.clr_i = 1'b0;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        tick(2);
        n_checks++;
        if ({bm.valid_o, bm.sec_o, bm.ded_o, bm.ded_sticky_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bm.valid_o, bm.sec_o, bm.ded_o, bm.ded_sticky_o});
        end
        n_checks++;
        if ({bm.data_o, bm.cnt_sec_o, bm.cnt_ded_o} !== 27'h0) begin
            n_fail++;
            $display("FAIL reset_data_cnt: got %h want 0", {bm.data_o, bm.cnt_sec_o, bm.cnt_ded_o});
        end
        rstn = 1'b1;
        tick(2);
        n_checks++;
        if ({bm.valid_o, bm.data_o, bp.valid_o} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_empty_hold: got %h want 0", {bm.valid_o, bm.data_o, bp.valid_o});
        end
    endtask

    task automatic test_clean();
        load_main(16'hB44B, 16'h0);
        n_checks++;
        if ({bm.valid_o, bm.sec_o, bm.ded_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL clean_k1: got %b want 000", {bm.valid_o, bm.sec_o, bm.ded_o});
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            n_checks++;
            if ({bm.valid_o, bm.sec_o, bm.ded_o, bm.data_o} !== {3'b100, 11'h5A5}) begin
                n_fail++;
                $display("FAIL clean_valid[%0d]: got v=%b s=%b d=%b data=%h want 1 0 0 5a5",
                         i, bm.valid_o, bm.sec_o, bm.ded_o, bm.data_o);
            end
        end
    endtask

    task automatic test_single_data();
        load_main(16'hB44B, 16'h0040);
        n_checks++;
        if ({bm.sec_o, bm.ded_o, bm.valid_o, bm.data_o} !== {3'b100, 11'h5A1}) begin
            n_fail++;
            $display("FAIL sec_k1: got s=%b d=%b v=%b data=%h want 1 0 0 5a1",
                     bm.sec_o, bm.ded_o, bm.valid_o, bm.data_o);
        end
        tick(1);
        n_checks++;
        if ({bm.sec_o, bm.valid_o, bm.cnt_sec_o} !== {2'b00, 8'd1}) begin
            n_fail++;
            $display("FAIL sec_k2_scrub: got s=%b v=%b cnt=%0d want 0 0 1",
                     bm.sec_o, bm.valid_o, bm.cnt_sec_o);
        end
        tick(1);
        n_checks++;
        if ({bm.sec_o, bm.valid_o, bm.data_o} !== {2'b00, 11'h5A5}) begin
            n_fail++;
            $display("FAIL sec_k3_restored: got s=%b v=%b data=%h want 0 0 5a5",
                     bm.sec_o, bm.valid_o, bm.data_o);
        end
        tick(1);
        n_checks++;
        if ({bm.valid_o, bm.data_o, bm.cnt_sec_o} !== {1'b1, 11'h5A5, 8'd1}) begin
            n_fail++;
            $display("FAIL sec_k4_valid: got v=%b data=%h cnt=%0d want 1 5a5 1",
                     bm.valid_o, bm.data_o, bm.cnt_sec_o);
        end
    endtask

    task automatic test_single_parity();
        clr_main();
        n_checks++;
        if (bm.cnt_sec_o !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_cnt_sec: got %0d want 0", bm.cnt_sec_o);
        end
        load_main(16'hB44B, 16'h0001);
        n_checks++;
        if ({bm.sec_o, bm.ded_o, bm.data_o} !== {2'b10, 11'h5A5}) begin
            n_fail++;
            $display("FAIL par_k1: got s=%b d=%b data=%h want 1 0 5a5",
                     bm.sec_o, bm.ded_o, bm.data_o);
        end
        tick(3);
        n_checks++;
        if ({bm.valid_o, bm.data_o, bm.cnt_sec_o} !== {1'b1, 11'h5A5, 8'd1}) begin
            n_fail++;
            $display("FAIL par_k4: got v=%b data=%h cnt=%0d want 1 5a5 1",
                     bm.valid_o, bm.data_o, bm.cnt_sec_o);
        end
    endtask

    task automatic test_double();
        load_main(16'hB44B, 16'h0204);
        n_checks++;
        if ({bm.ded_o, bm.sec_o, bm.valid_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL ded_k1: got d=%b s=%b v=%b want 1 0 0", bm.ded_o, bm.sec_o, bm.valid_o);
        end
        tick(1);
        n_checks++;
        if ({bm.ded_o, bm.valid_o, bm.ded_sticky_o, bm.cnt_ded_o, bm.data_o}
            !== {3'b001, 8'd1, 11'h5B5}) begin
            n_fail++;
            $display("FAIL ded_fault: got d=%b v=%b st=%b cnt=%0d data=%h want 0 0 1 1 5b5",
                     bm.ded_o, bm.valid_o, bm.ded_sticky_o, bm.cnt_ded_o, bm.data_o);
        end
        clr_main();
        n_checks++;
        if ({bm.ded_sticky_o, bm.cnt_ded_o, bm.cnt_sec_o} !== 17'h0) begin
            n_fail++;
            $display("FAIL ded_clr: got st=%b cnt_ded=%0d cnt_sec=%0d want 0 0 0",
                     bm.ded_sticky_o, bm.cnt_ded_o, bm.cnt_sec_o);
        end
        tick(3);
        n_checks++;
        if ({bm.valid_o, bm.ded_o, bm.cnt_ded_o} !== 10'h0) begin
            n_fail++;
            $display("FAIL ded_stays_fault: got v=%b d=%b cnt=%0d want 0 0 0",
                     bm.valid_o, bm.ded_o, bm.cnt_ded_o);
        end
        load_main(16'hB44B, 16'h0);
        tick(1);
        n_checks++;
        if ({bm.valid_o, bm.data_o} !== {1'b1, 11'h5A5}) begin
            n_fail++;
            $display("FAIL ded_reload: got v=%b data=%h want 1 5a5", bm.valid_o, bm.data_o);
        end
    endtask

    task automatic test_clr_vs_event();
        load_main(16'hB44B, 16'h0040);
        bm.clr_i = 1'b1;
        @(negedge clk);
        bm.clr_i = 1'b0;
        n_checks++;
        if (bm.cnt_sec_o !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_wins: got cnt_sec=%0d want 0", bm.cnt_sec_o);
        end
        tick(2);
        load_main(16'hB44B, 16'h0040);
        tick(1);
        n_checks++;
        if (bm.cnt_sec_o !== 8'd1) begin
            n_fail++;
            $display("FAIL count_after_clr: got cnt_sec=%0d want 1", bm.cnt_sec_o);
        end
        tick(2);
    endtask

    task automatic test_load_over_scrub();
        load_main(16'hB44B, 16'h0040);
        tick(1);
        bm.load_i = 1'b1;
        bm.hv_i   = 16'hFFFF;
        @(negedge clk);
        bm.load_i = 1'b0;
        n_checks++;
        if ({bm.sec_o, bm.ded_o, bm.data_o} !== {2'b00, 11'h7FF}) begin
            n_fail++;
            $display("FAIL load_over_scrub_k1: got s=%b d=%b data=%h want 0 0 7ff",
                     bm.sec_o, bm.ded_o, bm.data_o);
        end
        tick(1);
        n_checks++;
        if ({bm.valid_o, bm.data_o} !== {1'b1, 11'h7FF}) begin
            n_fail++;
            $display("FAIL load_over_scrub_k2: got v=%b data=%h want 1 7ff", bm.valid_o, bm.data_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bm.load_i = 1'b1;
        bm.hv_i   = 16'hB44B;
        @(negedge clk);
        bm.hv_i   = 16'h0000;
        @(negedge clk);
        bm.load_i = 1'b0;
        n_checks++;
        if ({bm.valid_o, bm.data_o} !== 12'h0) begin
            n_fail++;
            $display("FAIL b2b_check: got v=%b data=%h want 0 000", bm.valid_o, bm.data_o);
        end
        tick(1);
        n_checks++;
        if ({bm.valid_o, bm.data_o} !== {1'b1, 11'h000}) begin
            n_fail++;
            $display("FAIL b2b_valid: got v=%b data=%h want 1 000", bm.valid_o, bm.data_o);
        end
        load_main(16'hFFFF, 16'h0);
        n_checks++;
        if (bm.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop_on_load: got %b want 0", bm.valid_o);
        end
    endtask

    task automatic test_periodic();
        @(negedge clk);
        bp.load_i     = 1'b1;
        bp.hv_i       = 16'hB44B;
        bp.inj_mask_i = 16'h0;
        @(negedge clk);
        bp.load_i     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic exp_v;
            tick(1);
            exp_v = ((i % 5) != 4);
            n_checks++;
            if ({bp.valid_o, bp.sec_o} !== {exp_v, 1'b0}) begin
                n_fail++;
                $display("FAIL periodic[%0d]: got v=%b s=%b want %b 0", i, bp.valid_o, bp.sec_o, exp_v);
            end
        end
        // Land the load in the cycle where the timer expires.
        tick(4);
        bp.load_i     = 1'b1;
        bp.hv_i       = 16'hFFFF;
        bp.inj_mask_i = 16'h0040;
        @(negedge clk);
        bp.load_i     = 1'b0;
        bp.inj_mask_i = 16'h0;
        n_checks++;
        if ({bp.sec_o, bp.valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL expiry_load_sec: got s=%b v=%b want 1 0", bp.sec_o, bp.valid_o);
        end
        tick(3);
        n_checks++;
        if ({bp.valid_o, bp.data_o, bp.cnt_sec_o} !== {1'b1, 11'h7FF, 8'd1}) begin
            n_fail++;
            $display("FAIL expiry_load_data: got v=%b data=%h cnt=%0d want 1 7ff 1",
                     bp.valid_o, bp.data_o, bp.cnt_sec_o);
        end
    endtask

    task automatic test_saturate_and_reset();
        clr_main();
        for (int i = 0; i < 300; i++) begin
            load_main(16'hB44B, 16'h0040);
            tick(2);
            if (i == 253 || i == 254 || i == 299) begin
                logic [7:0] exp_c;
                exp_c = (i == 253) ? 8'd254 : 8'd255;
                n_checks++;
                if (bm.cnt_sec_o !== exp_c) begin
                    n_fail++;
                    $display("FAIL saturate[%0d]: got %0d want %0d", i, bm.cnt_sec_o, exp_c);
                end
            end
        end
        load_main(16'hB44B, 16'h0204);
        tick(1);
        load_main(16'hB44B, 16'h0040);
        tick(1);
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if ({bm.valid_o, bm.sec_o, bm.ded_o, bm.ded_sticky_o, bm.data_o, bm.cnt_sec_o, bm.cnt_ded_o}
            !== 31'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b st=%b data=%h cs=%0d cd=%0d want all 0",
                     bm.valid_o, bm.ded_sticky_o, bm.data_o, bm.cnt_sec_o, bm.cnt_ded_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick(3);
        n_checks++;
        if ({bm.valid_o, bm.data_o, bm.sec_o} !== 13'h0) begin
            n_fail++;
            $display("FAIL no_writeback_after_reset: got v=%b data=%h s=%b want 0 000 0",
                     bm.valid_o, bm.data_o, bm.sec_o);
        end
    endtask

    initial begin
        bm.load_i = 1'b0; bm.hv_i = 16'h0; bm.inj_mask_i = 16'h0; bm.clr_i = 1'b0;
        bp.load_i = 1'b0; bp.hv_i = 16'h0; bp.inj_mask_i = 16'h0; bp.clr_i = 1'b0;
        test_reset();
        test_clean();
        test_single_data();
        test_single_parity();
        test_double();
        test_clr_vs_event();
        test_load_over_scrub();
        test_back_to_back();
        test_periodic();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
